apb_timer_arb: RTL and testbench

APB_TIMER_ARB -- requirements
Module: apb_timer_arb

---
 rtl/apb_timer_arb_pkg.sv | 13 +
 rtl/apb_timer_arb_if.sv | 45 ++++
 rtl/apb_rr_pick.sv | 39 +++
 rtl/apb_timer_arb.sv | 147 ++++++++++++++
 tb/tb_apb_timer_arb.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_timer_arb_pkg.sv
// Shared types and default widths for the APB timer arbiter.
package apb_timer_arb_pkg;

    localparam int DefAddrWidth = 12;
    localparam int DefDataWidth = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } arb_state_e;

endpackage

// File: rtl/apb_timer_arb_if.sv
// Bus bundle for the APB timer arbiter: per-requester APB ports on one side,
// the shared timer-side APB master on the other.
// slave  : arbiter view (requester requests and timer responses are inputs)
// master : environment view (drives requests and timer responses)
interface apb_timer_arb_if
    import apb_timer_arb_pkg::*;
#(
    parameter int NumReq    = 2,
    parameter int AddrWidth = DefAddrWidth,
    parameter int DataWidth = DefDataWidth
);

    logic [NumReq-1:0]                req_psel_i;
    logic [NumReq-1:0]                req_penable_i;
    logic [NumReq-1:0]                req_pwrite_i;
    logic [NumReq-1:0][AddrWidth-1:0] req_paddr_i;
    logic [NumReq-1:0][DataWidth-1:0] req_pwdata_i;
    logic [NumReq-1:0][DataWidth-1:0] req_prdata_o;
    logic [NumReq-1:0]                req_pready_o;
    logic [NumReq-1:0]                req_pslverr_o;

    logic                 psel_o;
    logic                 penable_o;
    logic                 pwrite_o;
    logic [AddrWidth-1:0] paddr_o;
    logic [DataWidth-1:0] pwdata_o;
    logic [DataWidth-1:0] prdata_i;
    logic                 pready_i;
    logic                 pslverr_i;

    modport slave (
        input  req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
        output req_prdata_o, req_pready_o, req_pslverr_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        input  prdata_i, pready_i, pslverr_i
    );

    modport master (
        output req_psel_i, req_penable_i, req_pwrite_i, req_paddr_i, req_pwdata_i,
        input  req_prdata_o, req_pready_o, req_pslverr_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o,
        output prdata_i, pready_i, pslverr_i
    );

endinterface

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting one
// position after the last winner and wrapping around.
module apb_rr_pick #(
    parameter int NumReq = 2
) (
    input  logic [NumReq-1:0]         req,
    input  logic [$clog2(NumReq)-1:0] last_idx,
    output logic [NumReq-1:0]         grant,
    output logic [$clog2(NumReq)-1:0] grant_idx,
    output logic                      valid
);

    localparam int IdxW = $clog2(NumReq);

    logic [IdxW:0]   sum;
    logic [IdxW-1:0] cand;

    // First requester found walking upward from last_idx+1, modulo NumReq.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = 1; k <= NumReq; k++) begin
            sum = {1'b0, last_idx} + (IdxW+1)'(k);
            if (sum >= (IdxW+1)'(NumReq)) begin
                sum = sum - (IdxW+1)'(NumReq);
            end
            cand = sum[IdxW-1:0];
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant_idx   = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_timer_arb.sv
// APB timer arbiter: funnels NumReq APB requesters onto one timer-side APB
// master, round-robin, one transfer at a time.
// Optional feature macro: APB_TIMER_ARB_TIMEOUT_EN adds an ACCESS-phase
// watchdog that completes a stalled transfer with an error after
// TimeoutCycles cycles. Without it ACCESS waits for pready_i indefinitely.
//
// state  | meaning
// IDLE   | no transfer; pick a winner when any requester selects
// SETUP  | psel high, penable low, latched fields driven
// ACCESS | psel and penable high, waiting for pready_i (or watchdog)
module apb_timer_arb
    import apb_timer_arb_pkg::*;
#(
    parameter int NumReq        = 2,
    parameter int AddrWidth     = DefAddrWidth,
    parameter int DataWidth     = DefDataWidth,
    parameter int TimeoutCycles = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    apb_timer_arb_if.slave      bus,
    output logic [NumReq-1:0]   grant_o,
    output logic                timeout_o
);

    localparam int IdxW = $clog2(NumReq);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETUP  = ST_SETUP;
    localparam logic [1:0] S_ACCESS = ST_ACCESS;

    logic [1:0]           state_q;
    logic [IdxW-1:0]      last_q;
    logic [IdxW-1:0]      idx_q;
    logic [NumReq-1:0]    grant_q;
    logic [AddrWidth-1:0] paddr_q;
    logic [DataWidth-1:0] pwdata_q;
    logic                 pwrite_q;

    logic [NumReq-1:0]    pick_grant;
    logic [IdxW-1:0]      pick_idx;
    logic                 pick_valid;

    logic in_access;
    logic done;
    logic tmo;
    logic finish;
    logic rsp_ok;
    logic unused_in;

    apb_rr_pick #(.NumReq(NumReq)) u_pick (
        .req       (bus.req_psel_i),
        .last_idx  (last_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .valid     (pick_valid)
    );

    assign in_access = (state_q == S_ACCESS);
    assign done      = in_access & bus.pready_i;
    assign finish    = done | tmo;
    // A transfer caught by reset is abandoned, so nothing is answered then.
    assign rsp_ok    = finish & ~rst_i;

`ifdef APB_TIMER_ARB_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    logic [CntW-1:0] cnt_q;

    assign tmo       = in_access & ~bus.pready_i & (cnt_q == CntW'(TimeoutCycles - 1));
    assign unused_in = ^bus.req_penable_i;

    // Watchdog: counts ACCESS cycles without pready_i, restarts each transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == S_SETUP) begin
            cnt_q <= '0;
        end else if (in_access && !bus.pready_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    // TimeoutCycles has no effect here; kept so both builds share one port list.
    assign tmo       = 1'b0;
    assign unused_in = ^{bus.req_penable_i, (TimeoutCycles % 2 == 1)};
`endif

    // Sequencer: grant, latch winner's fields, walk SETUP -> ACCESS -> IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            last_q   <= IdxW'(NumReq - 1);
            idx_q    <= '0;
            grant_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q  <= S_SETUP;
                        idx_q    <= pick_idx;
                        grant_q  <= pick_grant;
                        paddr_q  <= bus.req_paddr_i[pick_idx];
                        pwdata_q <= bus.req_pwdata_i[pick_idx];
                        pwrite_q <= bus.req_pwrite_i[pick_idx];
                    end
                end
                S_SETUP: begin
                    state_q <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (finish) begin
                        state_q <= S_IDLE;
                        last_q  <= idx_q;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output drive; everything reads zero while reset is asserted.
    always_comb begin
        bus.psel_o        = ~rst_i & (state_q != S_IDLE);
        bus.penable_o     = ~rst_i & in_access;
        bus.pwrite_o      = ~rst_i & pwrite_q;
        bus.paddr_o       = rst_i ? '0 : paddr_q;
        bus.pwdata_o      = rst_i ? '0 : pwdata_q;
        grant_o           = rst_i ? '0 : grant_q;
        timeout_o         = ~rst_i & tmo;
        bus.req_pready_o  = rsp_ok ? grant_q : '0;
        bus.req_pslverr_o = (rsp_ok & (tmo | bus.pslverr_i)) ? grant_q : '0;
        bus.req_prdata_o  = '0;
        for (int r = 0; r < NumReq; r++) begin
            if (rsp_ok && done && grant_q[r]) begin
                bus.req_prdata_o[r] = bus.prdata_i;
            end
        end
    end

endmodule

// File: tb/tb_apb_timer_arb.sv
// Self-checking bench for apb_timer_arb: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a transfer-level model.
module tb_apb_timer_arb;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int TO = 4;

`ifdef APB_TIMER_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] grant;
    logic         tmo;

    apb_timer_arb_if #(.NumReq(N), .AddrWidth(AW), .DataWidth(DW)) bus ();

    apb_timer_arb #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus.slave),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Transfer-level model: a transfer is "busy" from grant to completion and
    // has an age (0 = setup cycle, k = k-th access cycle).
    bit            m_busy;
    int            m_age;
    int            m_owner;
    int            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_write;

    // Snapshot of DUT outputs from the most recent cycle.
    logic                o_psel, o_pen, o_pwrite, o_tmo;
    logic [AW-1:0]       o_paddr;
    logic [DW-1:0]       o_pwdata;
    logic [N-1:0]        o_grant, o_rready, o_rerr;
    logic [N-1:0][DW-1:0] o_rdata;

    function automatic int rr_winner(logic [N-1:0] r, int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    // One clock cycle: inputs already applied at the falling edge; compare just
    // before the rising edge, advance the model, move to the next falling edge.
    task automatic cyc();
        bit                   fin, to, live;
        int                   w;
        logic [N-1:0]         e_grant, e_rready, e_rerr;
        logic [N-1:0][DW-1:0] e_rdata;
        #4;
        live     = !rst && m_busy;
        to       = TMO_EN && live && m_age == TO && !bus.pready_i;
        fin      = live && m_age >= 1 && (bus.pready_i || to);
        e_grant  = live ? (N'(1) << m_owner) : '0;
        e_rready = '0;
        e_rerr   = '0;
        e_rdata  = '0;
        if (fin) begin
            e_rready[m_owner] = 1'b1;
            e_rerr[m_owner]   = bus.pready_i ? bus.pslverr_i : 1'b1;
            if (bus.pready_i) e_rdata[m_owner] = bus.prdata_i;
        end
        o_psel   = bus.psel_o;
        o_pen    = bus.penable_o;
        o_pwrite = bus.pwrite_o;
        o_paddr  = bus.paddr_o;
        o_pwdata = bus.pwdata_o;
        o_grant  = grant;
        o_tmo    = tmo;
        o_rready = bus.req_pready_o;
        o_rerr   = bus.req_pslverr_o;
        o_rdata  = bus.req_prdata_o;
        check_val("psel", o_psel, live);
        check_val("penable", o_pen, live && m_age >= 1);
        check_val("pwrite", o_pwrite, rst ? 1'b0 : m_write);
        check_val("paddr", o_paddr, rst ? '0 : m_addr);
        check_val("pwdata", o_pwdata, rst ? '0 : m_data);
        check_val("grant", o_grant, e_grant);
        check_val("timeout", o_tmo, fin && !bus.pready_i);
        check_val("req_pready", o_rready, e_rready);
        check_val("req_pslverr", o_rerr, e_rerr);
        check_val("req_prdata", o_rdata, e_rdata);
        if (rst) begin
            m_busy  = 0;
            m_age   = 0;
            m_last  = N - 1;
            m_addr  = '0;
            m_data  = '0;
            m_write = 1'b0;
        end else if (!m_busy) begin
            w = rr_winner(bus.req_psel_i, m_last);
            if (w >= 0) begin
                m_busy  = 1;
                m_owner = w;
                m_age   = 0;
                m_addr  = bus.req_paddr_i[w];
                m_data  = bus.req_pwdata_i[w];
                m_write = bus.req_pwrite_i[w];
            end
        end else if (fin) begin
            m_busy = 0;
            m_last = m_owner;
        end else begin
            m_age++;
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        bus.req_psel_i    = '0;
        bus.req_penable_i = '0;
        bus.req_pwrite_i  = '0;
        bus.req_paddr_i   = '0;
        bus.req_pwdata_i  = '0;
        bus.prdata_i      = '0;
        bus.pready_i      = 1'b0;
        bus.pslverr_i     = 1'b0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    function automatic int onehot_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int owners[$];
        int stamps[$];
        int done_at;
        int pulses;
        rst = 1'b1;
        quiet();
        m_busy = 0; m_age = 0; m_owner = 0; m_last = N - 1;
        m_addr = '0; m_data = '0; m_write = 1'b0;
        @(negedge clk);

        // Reset state.
        do_reset();
        cyc();
        check_val("rst_grant", o_grant, '0);
        check_val("rst_paddr", o_paddr, '0);

        // Single write from requester 0, pready in first access cycle.
        bus.req_psel_i      = 3'b001;
        bus.req_pwrite_i    = 3'b001;
        bus.req_paddr_i[0]  = 12'h004;
        bus.req_pwdata_i[0] = 32'h0000_00FF;
        bus.pready_i        = 1'b1;
        cyc();
        check_val("w_req_cycle_psel", o_psel, 1'b0);
        cyc();
        check_val("w_setup_psel", o_psel, 1'b1);
        check_val("w_setup_penable", o_pen, 1'b0);
        check_val("w_setup_grant", o_grant, 3'b001);
        check_val("w_setup_paddr", o_paddr, 12'h004);
        cyc();
        check_val("w_access_penable", o_pen, 1'b1);
        check_val("w_access_pready", o_rready, 3'b001);
        check_val("w_access_grant", o_grant, 3'b001);
        check_val("w_access_pwdata", o_pwdata, 32'h0000_00FF);
        bus.req_psel_i = '0;
        cyc();
        check_val("w_idle_grant", o_grant, '0);
        check_val("w_idle_paddr_hold", o_paddr, 12'h004);

        // Two requesters contending: alternate, one idle cycle between.
        do_reset();
        bus.req_psel_i     = 3'b011;
        bus.req_paddr_i[0] = 12'h010;
        bus.req_paddr_i[1] = 12'h020;
        bus.pready_i       = 1'b1;
        for (int c = 0; c < 13; c++) begin
            cyc();
            if (o_rready != '0) begin
                owners.push_back(onehot_idx(o_rready));
                stamps.push_back(c);
            end
        end
        check_val("rr_count", owners.size() >= 4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (i < owners.size()) check_val("rr_order", owners[i], i % 2);
            if (i > 0 && i < stamps.size()) check_val("rr_spacing", stamps[i] - stamps[i-1], 3);
        end

        // Read from requester 1 with 3 wait cycles and an error response.
        do_reset();
        bus.req_psel_i     = 3'b010;
        bus.req_paddr_i[1] = 12'($urandom);
        cyc();
        cyc();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check_val("rd_wait_pready", o_rready, '0);
        end
        bus.pready_i  = 1'b1;
        bus.prdata_i  = 32'hDEAD_BEEF;
        bus.pslverr_i = 1'b1;
        cyc();
        check_val("rd_data_req1", o_rdata[1], 32'hDEAD_BEEF);
        check_val("rd_data_req0", o_rdata[0], '0);
        check_val("rd_pready", o_rready, 3'b010);
        check_val("rd_pslverr", o_rerr, 3'b010);
        bus.req_psel_i = '0;
        cyc();
        check_val("rd_after_data", o_rdata, '0);
        check_val("rd_after_pslverr", o_rerr, '0);

        // Reset during ACCESS abandons the transfer; requester 0 wins next.
        do_reset();
        bus.req_psel_i = 3'b010;
        cyc();
        cyc();
        cyc();
        rst          = 1'b1;
        bus.pready_i = 1'b1;
        cyc();
        check_val("rsta_pready", o_rready, '0);
        rst            = 1'b0;
        bus.pready_i   = 1'b0;
        bus.req_psel_i = 3'b011;
        cyc();
        check_val("rsta_psel", o_psel, 1'b0);
        check_val("rsta_penable", o_pen, 1'b0);
        check_val("rsta_grant", o_grant, '0);
        cyc();
        check_val("rsta_first_winner", o_grant, 3'b001);

        // Stalled slave: watchdog completion or indefinite wait.
        do_reset();
        bus.req_psel_i = 3'b001;
        cyc();
        cyc();
        done_at = 0;
        pulses  = 0;
`ifdef APB_TIMER_ARB_TIMEOUT_EN
        for (int k = 1; k <= 8 && done_at == 0; k++) begin
            cyc();
            if (o_rready != '0) begin
                done_at = k;
                check_val("wd_pslverr", o_rerr, 3'b001);
                check_val("wd_timeout", o_tmo, 1'b1);
            end
        end
        check_val("wd_access_cycle", done_at, TO);
`else
        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (o_rready != '0) pulses++;
        end
        check_val("stall_no_completion", pulses, 0);
        check_val("stall_still_access", {o_psel, o_pen}, 2'b11);
`endif

        // Randomized traffic with occasional reset.
        do_reset();
        for (int c = 0; c < 500; c++) begin
            rst               = ($urandom_range(0, 59) == 0);
            bus.req_psel_i    = N'($urandom);
            bus.req_penable_i = N'($urandom);
            bus.req_pwrite_i  = N'($urandom);
            for (int r = 0; r < N; r++) begin
                bus.req_paddr_i[r]  = AW'($urandom);
                bus.req_pwdata_i[r] = $urandom;
            end
            bus.pready_i  = ($urandom_range(0, 2) != 0);
            bus.prdata_i  = $urandom;
            bus.pslverr_i = 1'($urandom);
            cyc();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
